// File: rtl/async_fifo_pkg.sv
// Shared pointer type and Gray/binary conversions for the async FIFO pointer blocks.
// Conversions run on a 32-bit word so every pointer width can share them.
package async_fifo_pkg;

    localparam int ADDRSIZE_DEFAULT = 4;
    localparam int CONV_W           = 32;

    typedef logic [ADDRSIZE_DEFAULT:0] ptr_t;
    typedef logic [CONV_W-1:0]         conv_t;

    function automatic conv_t bin2gray(input conv_t bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Zero-extended inputs convert correctly: leading zeros leave the XOR chain unchanged.
    function automatic conv_t gray2bin(input conv_t gray);
        conv_t bin;
        bin[CONV_W-1] = gray[CONV_W-1];
        for (int i = CONV_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Width-parametrised combinational Gray-to-binary converter.
module gray2bin
    import async_fifo_pkg::conv_t;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    assign o_bin = WIDTH'(async_fifo_pkg::gray2bin(conv_t'(i_gray)));

endmodule

// File: rtl/wptr_full_prog.sv
// Write-side pointer and flag logic of an async FIFO: Gray write pointer, full,
// programmable almost-full, write-side fill level and a sticky overflow flag.
module wptr_full_prog
    import async_fifo_pkg::bin2gray;
    import async_fifo_pkg::conv_t;
#(
    parameter int ADDRSIZE = async_fifo_pkg::ADDRSIZE_DEFAULT
) (
    input  logic                wclk_i,
    input  logic                wrst_i,
    input  logic                wen,
    input  logic [ADDRSIZE:0]   rptr_sync2_wrclk,
    input  logic [ADDRSIZE:0]   af_thresh_i,
    input  logic                ovf_clr_i,
    output logic                wr_accept,
    output logic [ADDRSIZE-1:0] wr_addr,
    output logic [ADDRSIZE:0]   wptr_g,
    output logic                fifo_full,
    output logic                fifo_almost_full,
    output logic [ADDRSIZE:0]   wr_level,
    output logic                overflow
);

    localparam int              PTR_W   = ADDRSIZE + 1;
    localparam int              DEPTH   = 2 ** ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_P = PTR_W'(DEPTH);

    logic [ADDRSIZE:0] r_wbin;
    logic [ADDRSIZE:0] r_wptr_g;
    logic [ADDRSIZE:0] r_level;
    logic              r_full;
    logic              r_almost_full;
    logic              r_overflow;

    logic              w_wr_accept;
    logic [ADDRSIZE:0] w_wbin_next;
    logic [ADDRSIZE:0] w_rbin;
    logic [ADDRSIZE:0] w_level_next;

    gray2bin #(
        .WIDTH (PTR_W)
    ) u_rptr_g2b (
        .i_gray (rptr_sync2_wrclk),
        .o_bin  (w_rbin)
    );

    // Flags are computed from the post-write pointer so a write shows up after one edge.
    assign w_wr_accept  = wen & ~r_full;
    assign w_wbin_next  = r_wbin + PTR_W'(w_wr_accept);
    assign w_level_next = w_wbin_next - w_rbin;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wclk_i) begin
        if (wrst_i) begin
            r_wbin        <= '0;
            r_wptr_g      <= '0;
            r_level       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_wbin        <= w_wbin_next;
            r_wptr_g      <= PTR_W'(bin2gray(conv_t'(w_wbin_next)));
            r_level       <= w_level_next;
            r_full        <= (w_level_next == DEPTH_P);
            r_almost_full <= (w_level_next >= af_thresh_i);
            // A refused write outranks a same-cycle clear.
            if (wen && r_full) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign wr_accept        = w_wr_accept;
    assign wr_addr          = r_wbin[ADDRSIZE-1:0];
    assign wptr_g           = r_wptr_g;
    assign fifo_full        = r_full;
    assign fifo_almost_full = r_almost_full;
    assign wr_level         = r_level;
    assign overflow         = r_overflow;

endmodule

// File: tb/tb_wptr_full_prog.sv
// Directed, scoreboard-checked bench for wptr_full_prog at ADDRSIZE=2 (DEPTH=4).
module tb_wptr_full_prog;

    logic       wclk_i = 1'b0;
    logic       wrst_i = 1'b1;
    logic       wen = 1'b0;
    logic [2:0] rptr_sync2_wrclk = '0;
    logic [2:0] af_thresh_i = '0;
    logic       ovf_clr_i = 1'b0;
    logic       wr_accept;
    logic [1:0] wr_addr;
    logic [2:0] wptr_g;
    logic       fifo_full;
    logic       fifo_almost_full;
    logic [2:0] wr_level;
    logic       overflow;

    wptr_full_prog #(.ADDRSIZE(2)) dut (
        .wclk_i           (wclk_i),
        .wrst_i           (wrst_i),
        .wen              (wen),
        .rptr_sync2_wrclk (rptr_sync2_wrclk),
        .af_thresh_i      (af_thresh_i),
        .ovf_clr_i        (ovf_clr_i),
        .wr_accept        (wr_accept),
        .wr_addr          (wr_addr),
        .wptr_g           (wptr_g),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .wr_level         (wr_level),
        .overflow         (overflow)
    );

    always #5 wclk_i = ~wclk_i;

    typedef struct {
        logic       full;
        logic       af;
        logic [2:0] level;
        logic [2:0] gptr;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: accepted-write count and read index, both modulo 8.
    int m_w = 0;
    int m_r = 0;
    bit m_full = 0;
    bit m_af = 0;
    bit m_ovf = 0;
    int m_lvl = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit w, input int r, input int thr, input bit clr, input bit rst);
        exp_t e;
        bit   acc;
        int   g;
        @(negedge wclk_i);
        wen              = w;
        m_r              = r % 8;
        rptr_sync2_wrclk = 3'(m_r ^ (m_r >> 1));
        af_thresh_i      = 3'(thr);
        ovf_clr_i        = clr;
        wrst_i           = rst;
        #1;
        check("wr_accept", wr_accept, (w && !m_full) ? 1 : 0);
        check("wr_addr", wr_addr, m_w % 4);
        if (rst) begin
            m_w = 0; m_full = 0; m_af = 0; m_lvl = 0; m_ovf = 0;
        end else begin
            acc = w && !m_full;
            if (w && m_full) m_ovf = 1;
            else if (clr)    m_ovf = 0;
            m_w    = (m_w + (acc ? 1 : 0)) % 8;
            m_lvl  = (m_w - m_r + 8) % 8;
            m_full = (m_lvl == 4);
            m_af   = (m_lvl >= thr);
        end
        g       = m_w ^ (m_w >> 1);
        e.full  = m_full;
        e.af    = m_af;
        e.level = 3'(m_lvl);
        e.gptr  = 3'(g);
        e.ovf   = m_ovf;
        q.push_back(e);
        @(posedge wclk_i);
        #1;
        e = q.pop_front();
        check("fifo_full", fifo_full, e.full);
        check("almost_full", fifo_almost_full, e.af);
        check("wr_level", wr_level, e.level);
        check("wptr_g", wptr_g, e.gptr);
        check("overflow", overflow, e.ovf);
    endtask

    initial begin
        // Reset overrides a pending write.
        step(1, 0, 3, 0, 1);
        step(1, 0, 3, 0, 1);
        check("rst_level", wr_level, 0);

        // Fill: addresses 0..3, almost-full after 3rd, full after 4th, 5th refused.
        step(1, 0, 3, 0, 0);
        step(1, 0, 3, 0, 0);
        step(1, 0, 3, 0, 0);
        check("fill_af_after_3", fifo_almost_full, 1);
        check("fill_not_full_3", fifo_full, 0);
        step(1, 0, 3, 0, 0);
        check("fill_full_after_4", fifo_full, 1);
        step(1, 0, 3, 0, 0);
        check("fill_ovf", overflow, 1);

        // Overflow set beats a same-cycle clear, then a lone clear wins.
        step(1, 0, 3, 1, 0);
        check("ovf_set_wins", overflow, 1);
        step(0, 0, 3, 1, 0);
        check("ovf_cleared", overflow, 0);

        // Release: one read frees a slot, one write refills it.
        step(1, 1, 3, 0, 0);
        check("release_not_full", fifo_full, 0);
        step(1, 1, 3, 0, 0);
        check("release_full_again", fifo_full, 1);

        // Wrap: read pointer runs past 4 (Gray 110) while writes continue.
        for (int r = 2; r <= 9; r++) begin
            step(1, r, 3, 0, 0);
            check("wrap_level_le4", (wr_level <= 3'd4) ? 1 : 0, 1);
        end

        // Threshold 0: almost-full immediately after reset.
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        check("thr0_af", fifo_almost_full, 1);

        // Threshold 5: never asserts, even when full.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 5, 0, 0);
            check("thr5_no_af", fifo_almost_full, 0);
        end
        check("thr5_full", fifo_full, 1);

        // Threshold change is seen after exactly one edge.
        step(0, 0, 2, 1, 0);
        check("thr_change_af", fifo_almost_full, 1);
        step(0, 0, 5, 0, 0);
        check("thr_change_back", fifo_almost_full, 0);

        // Mid-run reset at level 3 with wen held high.
        step(0, 0, 3, 0, 1);
        step(1, 0, 3, 0, 0);
        step(1, 0, 3, 0, 0);
        step(1, 0, 3, 0, 0);
        check("midrst_level3", wr_level, 3);
        step(1, 0, 3, 0, 1);
        check("midrst_wptr", wptr_g, 0);
        check("midrst_full", fifo_full, 0);
        check("midrst_af", fifo_almost_full, 0);
        check("midrst_ovf", overflow, 0);
        step(1, 0, 3, 0, 0);
        check("midrst_level1", wr_level, 1);

        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
